// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, default framing constants and parity helper for the UART frame receiver
// Contents: parity_e (line parity mode), parser_state_e (frame parser states),
// core_state_e (character receiver states), DEF_SOF/DEF_EOF and parity_calc().
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        P_IDLE    = 3'd0,
        P_LEN     = 3'd1,
        P_CMD     = 3'd2,
        P_PAYLOAD = 3'd3,
        P_END     = 3'd4,
        P_HOLD    = 3'd5
    } parser_state_e;

    typedef enum logic [2:0] {
        C_IDLE  = 3'd0,
        C_START = 3'd1,
        C_DATA  = 3'd2,
        C_PAR   = 3'd3,
        C_STOP  = 3'd4
    } core_state_e;

    localparam int DEF_SOF    = 'hFE;
    localparam int DEF_EOF    = 'hEF;
    localparam int MAX_DATA_W = 9;

    // Parity bit a transmitter would append to data; narrower characters are
    // zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic parity_calc(input logic [MAX_DATA_W-1:0] data, input parity_e mode);
        case (mode)
            PAR_EVEN: return ^data;
            PAR_ODD:  return ~^data;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - asynchronous serial character receiver (synchroniser, bit timer, bit counter)
// Ports: clk, reset (async, active high), rx_in (serial line, idles high),
// char_strobe (one-cycle pulse on the stop-bit mid-sample), char_data (received character),
// par_bad / stop_bad (qualifiers valid with char_strobe), busy (mid-character).
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int      DATA_W       = 8,
    parameter int      CLKS_PER_BIT = 16,
    parameter parity_e PARITY       = PAR_EVEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_in,
    output logic              char_strobe,
    output logic [DATA_W-1:0] char_data,
    output logic              par_bad,
    output logic              stop_bad,
    output logic              busy
);

    // CLKS_PER_BIT >= 2 and DATA_W >= 5 keep both widths at least 1 bit.
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_W);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);

    logic              sync1, rx_s, rx_prev;
    core_state_e       state, state_d;
    logic [TW-1:0]     timer, timer_d;
    logic [BW-1:0]     bit_cnt, bit_cnt_d;
    logic [DATA_W-1:0] shift, shift_d;
    logic              par_bit, par_bit_d;
    logic              strobe_d, par_bad_d, stop_bad_d;
    logic              tick;

    // Synchroniser plus one extra stage for falling-edge detection; all reset
    // to the idle level so leaving reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= rx_in;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

    assign tick = (timer == '0);

    always_comb begin
        state_d    = state;
        timer_d    = timer;
        bit_cnt_d  = bit_cnt;
        shift_d    = shift;
        par_bit_d  = par_bit;
        strobe_d   = 1'b0;
        par_bad_d  = 1'b0;
        stop_bad_d = 1'b0;
        if (state != C_IDLE) begin
            timer_d = tick ? FULL_LOAD : timer - TW'(1);
        end
        case (state)
            C_IDLE: begin
                if (!rx_s && rx_prev) begin
                    state_d = C_START;
                    timer_d = HALF_LOAD;
                end
            end
            C_START: begin
                if (tick) begin
                    if (rx_s) begin
                        state_d = C_IDLE;
                    end else begin
                        state_d   = C_DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            C_DATA: begin
                if (tick) begin
                    // LSB arrives first, so shift in from the top.
                    shift_d   = {rx_s, shift[DATA_W-1:1]};
                    bit_cnt_d = bit_cnt + BW'(1);
                    if (bit_cnt == LAST_BIT) begin
                        state_d = (PARITY == PAR_NONE) ? C_STOP : C_PAR;
                    end
                end
            end
            C_PAR: begin
                if (tick) begin
                    par_bit_d = rx_s;
                    state_d   = C_STOP;
                end
            end
            C_STOP: begin
                if (tick) begin
                    state_d    = C_IDLE;
                    strobe_d   = 1'b1;
                    stop_bad_d = !rx_s;
                    par_bad_d  = (PARITY != PAR_NONE) &&
                                 (par_bit != parity_calc(MAX_DATA_W'(shift), PARITY));
                end
            end
            default: state_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= C_IDLE;
            timer       <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            par_bit     <= 1'b0;
            char_strobe <= 1'b0;
            par_bad     <= 1'b0;
            stop_bad    <= 1'b0;
        end else begin
            state       <= state_d;
            timer       <= timer_d;
            bit_cnt     <= bit_cnt_d;
            shift       <= shift_d;
            par_bit     <= par_bit_d;
            char_strobe <= strobe_d;
            par_bad     <= par_bad_d;
            stop_bad    <= stop_bad_d;
        end
    end

    // The shift register is untouched until the next character's first data
    // bit, well after the strobe cycle, so it doubles as the output latch.
    assign char_data = shift;
    assign busy      = (state != C_IDLE);

endmodule

// File: rtl/uart_cmd_frame_rx.sv
// rtl/uart_cmd_frame_rx.sv - UART receiver with SOF/L/CMD/payload/EOF command-frame parser
// Ports: clk, reset (async, active high), rx_in (serial line);
// frame_valid/frame_ack (held-frame handshake), frame_cmd, frame_len (payload count),
// rd_idx/rd_data (combinational payload read); parity_err, frame_err, overflow
// (one-cycle error pulses); busy (parser outside IDLE or character in flight).
module uart_cmd_frame_rx
    import uart_pkg::*;
#(
    parameter int                DATA_W       = 8,
    parameter int                CLKS_PER_BIT = 16,
    parameter parity_e           PARITY       = PAR_EVEN,
    parameter int                MAX_PAYLOAD  = 16,
    parameter logic [DATA_W-1:0] SOF          = DATA_W'(DEF_SOF),
    parameter logic [DATA_W-1:0] EOF          = DATA_W'(DEF_EOF)
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic                                                   rx_in,
    output logic                                                   frame_valid,
    input  logic                                                   frame_ack,
    output logic [DATA_W-1:0]                                      frame_cmd,
    output logic [$clog2(MAX_PAYLOAD+1)-1:0]                       frame_len,
    input  logic [((MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1)-1:0] rd_idx,
    output logic [DATA_W-1:0]                                      rd_data,
    output logic                                                   parity_err,
    output logic                                                   frame_err,
    output logic                                                   overflow,
    output logic                                                   busy
);

    localparam int LW  = $clog2(MAX_PAYLOAD + 1);
    localparam int IW  = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int LW1 = DATA_W + 1;
    // Largest acceptable L value (payload count + the CMD character).
    localparam logic [DATA_W:0] MAX_L = LW1'(MAX_PAYLOAD + 1);

    logic              char_strobe, par_bad, stop_bad, core_busy;
    logic [DATA_W-1:0] char_data;

    uart_rx_core #(
        .DATA_W       (DATA_W),
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .PARITY       (PARITY)
    ) u_core (
        .clk         (clk),
        .reset       (reset),
        .rx_in       (rx_in),
        .char_strobe (char_strobe),
        .char_data   (char_data),
        .par_bad     (par_bad),
        .stop_bad    (stop_bad),
        .busy        (core_busy)
    );

    parser_state_e     state, state_d;
    logic [LW-1:0]     cnt, cnt_d, len_q, len_d;
    logic [DATA_W-1:0] cmd_q, cmd_d;
    logic              parity_err_d, frame_err_d, overflow_d;
    logic              wr_en;
    logic [DATA_W-1:0] buffer [MAX_PAYLOAD];

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        len_d        = len_q;
        cmd_d        = cmd_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        overflow_d   = 1'b0;
        wr_en        = 1'b0;

        if (state == P_HOLD && frame_ack) begin
            state_d = P_IDLE;
        end

        if (char_strobe) begin
            if (stop_bad) begin
                frame_err_d = 1'b1;
            end else if (state == P_HOLD) begin
                // Still HOLD for this character even if frame_ack arrives
                // in the same cycle: the character cannot be stored.
                overflow_d   = 1'b1;
                parity_err_d = par_bad;
            end else if (par_bad) begin
                parity_err_d = 1'b1;
                if (state != P_IDLE) begin
                    frame_err_d = 1'b1;
                    state_d     = P_IDLE;
                end
            end else begin
                case (state)
                    P_IDLE: begin
                        if (char_data == SOF) begin
                            state_d = P_LEN;
                        end
                    end
                    P_LEN: begin
                        cnt_d = '0;
                        len_d = LW'(char_data - DATA_W'(1));
                        if (char_data == '0) begin
                            frame_err_d = 1'b1;
                            state_d     = P_IDLE;
                        end else if ({1'b0, char_data} > MAX_L) begin
                            overflow_d = 1'b1;
                            state_d    = P_IDLE;
                        end else begin
                            state_d = P_CMD;
                        end
                    end
                    P_CMD: begin
                        cmd_d   = char_data;
                        state_d = (len_q == '0) ? P_END : P_PAYLOAD;
                    end
                    P_PAYLOAD: begin
                        wr_en = 1'b1;
                        cnt_d = cnt + LW'(1);
                        if (cnt + LW'(1) == len_q) begin
                            state_d = P_END;
                        end
                    end
                    P_END: begin
                        if (char_data == EOF) begin
                            state_d = P_HOLD;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = P_IDLE;
                        end
                    end
                    default: state_d = P_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= P_IDLE;
            cnt        <= '0;
            len_q      <= '0;
            cmd_q      <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            len_q      <= len_d;
            cmd_q      <= cmd_d;
            parity_err <= parity_err_d;
            frame_err  <= frame_err_d;
            overflow   <= overflow_d;
        end
    end

    // Payload storage carries no reset; rd_data is masked by frame_len, which does.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buffer[cnt[IW-1:0]] <= char_data;
        end
    end

    assign rd_data     = (LW'(rd_idx) < len_q) ? buffer[rd_idx] : '0;
    assign frame_valid = (state == P_HOLD);
    assign frame_cmd   = cmd_q;
    assign frame_len   = len_q;
    assign busy        = (state != P_IDLE) || core_busy;

endmodule

// File: tb/tb_uart_cmd_frame_rx.sv
// tb/tb_uart_cmd_frame_rx.sv - randomized self-checking bench for uart_cmd_frame_rx
module tb_uart_cmd_frame_rx;
    import uart_pkg::*;

    localparam int C    = 4;
    localparam int DW   = 8;
    localparam int MAXP = 4;
    localparam int LW   = 3;
    localparam int IW   = 2;
    // Falling edge of the start bit to character strobe, in clock edges.
    localparam int CHAR_CYC = 2 + C / 2 + (1 + DW + 1) * C;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx_in = 1'b1;
    logic          frame_ack = 1'b0;
    logic [IW-1:0] rd_idx = '0;
    logic          frame_valid, parity_err, frame_err, overflow, busy;
    logic [DW-1:0] frame_cmd, rd_data;
    logic [LW-1:0] frame_len;

    uart_cmd_frame_rx #(
        .DATA_W       (DW),
        .CLKS_PER_BIT (C),
        .PARITY       (PAR_EVEN),
        .MAX_PAYLOAD  (MAXP),
        .SOF          (8'hFE),
        .EOF          (8'hEF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_in       (rx_in),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .frame_cmd   (frame_cmd),
        .frame_len   (frame_len),
        .rd_idx      (rd_idx),
        .rd_data     (rd_data),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_par = 0, n_frm = 0, n_ovf = 0, n_both = 0;
    int e_par = 0, e_frm = 0, e_ovf = 0, e_both = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (parity_err) n_par++;
            if (frame_err) n_frm++;
            if (overflow) n_ovf++;
            if (parity_err && frame_err) n_both++;
        end
    end

    // Reference model: a frame is SOF followed by L, CMD, L-1 payload bytes, EOF.
    bit         m_in = 0;
    bit         m_hold = 0;
    logic [7:0] m_q[$];
    logic [7:0] m_pay[$];
    logic [7:0] m_cmd = 8'h00;

    function automatic void model_char(input logic [7:0] c, input bit bad);
        if (m_hold) begin
            e_ovf++;
            if (bad) e_par++;
            return;
        end
        if (bad) begin
            e_par++;
            if (m_in) begin
                e_frm++;
                e_both++;
                m_in = 0;
            end
            return;
        end
        if (!m_in) begin
            if (c == 8'hFE) begin
                m_in = 1;
                m_q.delete();
            end
            return;
        end
        m_q.push_back(c);
        if (m_q.size() == 1) begin
            if (c == 8'h00) begin
                e_frm++;
                m_in = 0;
            end else if (int'(c) - 1 > MAXP) begin
                e_ovf++;
                m_in = 0;
            end
        end else if (m_q.size() == int'(m_q[0]) + 2) begin
            m_in = 0;
            if (c == 8'hEF) begin
                m_hold = 1;
                m_cmd  = m_q[1];
                m_pay.delete();
                for (int i = 2; i < m_q.size() - 1; i++) m_pay.push_back(m_q[i]);
            end else begin
                e_frm++;
            end
        end
    endfunction

    // Called on a negedge; returns on the negedge ending the stop bit.
    task automatic send_char(input logic [7:0] d, input bit bad);
        logic [10:0] bits;
        model_char(d, bad);
        bits = {1'b1, (^d) ^ bad, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx_in = bits[i];
            repeat (C) @(negedge clk);
        end
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send_char(s[i], 1'b0);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic do_ack();
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        m_hold = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({frame_valid, parity_err, frame_err, overflow, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 00000", {frame_valid, parity_err, frame_err, overflow, busy});
        end
        n_checks++;
        if ({frame_cmd, frame_len, rd_data} !== 19'h0) begin
            n_fail++;
            $display("FAIL reset_data: got cmd=%0h len=%0d rd=%0h required 0", frame_cmd, frame_len, rd_data);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic_frame();
        logic [7:0] q[$];
        logic [7:0] exp_rd[4];
        int t0, lat;
        exp_rd = '{8'h04, 8'h07, 8'h00, 8'h00};
        q = '{8'hFE, 8'h03, 8'h01, 8'h04, 8'h07};
        send_seq(q);
        t0 = cyc;
        send_char(8'hEF, 1'b0);
        lat = -1;
        for (int i = 0; i < 12 && lat < 0; i++) begin
            if (frame_valid) lat = cyc - t0;
            else @(negedge clk);
        end
        n_checks++;
        if (lat != CHAR_CYC + 2) begin
            n_fail++;
            $display("FAIL basic_valid_latency: got %0d required %0d", lat, CHAR_CYC + 2);
        end
        n_checks++;
        if (frame_cmd !== 8'h01 || frame_len !== 3'd2) begin
            n_fail++;
            $display("FAIL basic_cmd_len: got cmd=%0h len=%0d required 01/2", frame_cmd, frame_len);
        end
        for (int i = 0; i < MAXP; i++) begin
            rd_idx = IW'(i);
            #1;
            n_checks++;
            if (rd_data !== exp_rd[i]) begin
                n_fail++;
                $display("FAIL basic_rd[%0d]: got %0h required %0h", i, rd_data, exp_rd[i]);
            end
        end
        @(negedge clk);
        do_ack();
        n_checks++;
        if (frame_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_ack_drop: got %b required 0", frame_valid);
        end
        n_checks++;
        if ({n_par, n_frm, n_ovf} != 0) begin
            n_fail++;
            $display("FAIL basic_no_pulses: got par=%0d frm=%0d ovf=%0d required 0", n_par, n_frm, n_ovf);
        end
    endtask

    task automatic test_short_frame();
        logic [7:0] q[$];
        int p0, f0, o0;
        p0 = n_par; f0 = n_frm; o0 = n_ovf;
        q = '{8'h55, 8'hAA, 8'hFE, 8'h01, 8'h02, 8'hEF};
        send_seq(q);
        settle();
        rd_idx = '0;
        #1;
        n_checks++;
        if (frame_valid !== 1'b1 || frame_cmd !== 8'h02 || frame_len !== 3'd0 || rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL short_frame: got v=%b cmd=%0h len=%0d rd=%0h required 1/02/0/00", frame_valid, frame_cmd, frame_len, rd_data);
        end
        n_checks++;
        if (n_par != p0 || n_frm != f0 || n_ovf != o0) begin
            n_fail++;
            $display("FAIL short_junk_pulses: got par=%0d frm=%0d ovf=%0d required %0d/%0d/%0d", n_par, n_frm, n_ovf, p0, f0, o0);
        end
        @(negedge clk);
        do_ack();
    endtask

    task automatic test_parity_abort();
        logic [7:0] q[$];
        int b0;
        b0 = n_both;
        q = '{8'hFE, 8'h03};
        send_seq(q);
        send_char(8'h01, 1'b1);
        settle();
        n_checks++;
        if (n_both != b0 + 1 || n_both != e_both || n_par != e_par || n_frm != e_frm) begin
            n_fail++;
            $display("FAIL parity_abort: got both=%0d par=%0d frm=%0d required %0d/%0d/%0d", n_both, n_par, n_frm, b0 + 1, e_par, e_frm);
        end
        n_checks++;
        if (busy !== 1'b0 || frame_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_abort_idle: got busy=%b v=%b required 0/0", busy, frame_valid);
        end
        q = '{8'hFE, 8'h02, 8'h09, 8'h0A, 8'hEF};
        send_seq(q);
        settle();
        rd_idx = '0;
        #1;
        n_checks++;
        if (frame_valid !== 1'b1 || frame_cmd !== 8'h09 || frame_len !== 3'd1 || rd_data !== 8'h0A) begin
            n_fail++;
            $display("FAIL parity_recover: got v=%b cmd=%0h len=%0d rd=%0h required 1/09/1/0A", frame_valid, frame_cmd, frame_len, rd_data);
        end
        @(negedge clk);
        do_ack();
    endtask

    task automatic test_len_errors();
        logic [7:0] q[$];
        int o0, f0;
        o0 = n_ovf;
        q = '{8'hFE, 8'h06};
        send_seq(q);
        settle();
        n_checks++;
        if (n_ovf != o0 + 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL len_overflow: got ovf=%0d busy=%b required %0d/0", n_ovf, busy, o0 + 1);
        end
        f0 = n_frm;
        q = '{8'hFE, 8'h02, 8'h01, 8'h04, 8'h33};
        send_seq(q);
        settle();
        n_checks++;
        if (n_frm != f0 + 1 || frame_valid !== 1'b0 || n_frm != e_frm || n_ovf != e_ovf) begin
            n_fail++;
            $display("FAIL bad_eof: got frm=%0d v=%b required %0d/0", n_frm, frame_valid, f0 + 1);
        end
    endtask

    task automatic test_hold_and_glitch();
        logic [7:0] q[$];
        int o0, p0, f0;
        q = '{8'hFE, 8'h02, 8'h05, 8'h0C, 8'hEF};
        send_seq(q);
        settle();
        o0 = n_ovf;
        send_char(8'hFE, 1'b0);
        settle();
        rd_idx = '0;
        #1;
        n_checks++;
        if (n_ovf != o0 + 1) begin
            n_fail++;
            $display("FAIL hold_drop_ovf: got %0d required %0d", n_ovf, o0 + 1);
        end
        n_checks++;
        if (frame_valid !== 1'b1 || frame_cmd !== 8'h05 || frame_len !== 3'd1 || rd_data !== 8'h0C) begin
            n_fail++;
            $display("FAIL hold_unchanged: got v=%b cmd=%0h len=%0d rd=%0h required 1/05/1/0C", frame_valid, frame_cmd, frame_len, rd_data);
        end
        @(negedge clk);
        do_ack();
        o0 = n_ovf; p0 = n_par; f0 = n_frm;
        rx_in = 1'b0;
        repeat (2) @(negedge clk);
        rx_in = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++;
        if (n_ovf != o0 || n_par != p0 || n_frm != f0 || busy !== 1'b0 || frame_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch: got ovf=%0d par=%0d frm=%0d busy=%b v=%b required %0d/%0d/%0d/0/0", n_ovf, n_par, n_frm, busy, frame_valid, o0, p0, f0);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] q[$];
        logic [7:0] exp_rd[4];
        exp_rd = '{8'h11, 8'h22, 8'h00, 8'h00};
        q = '{8'hFE, 8'h03, 8'h01};
        send_seq(q);
        rx_in = 1'b0;
        repeat (3 * C) @(negedge clk);
        rx_in = 1'b1;
        repeat (C) @(negedge clk);
        reset = 1'b1;
        m_in = 0;
        m_hold = 0;
        #1;
        n_checks++;
        if ({frame_valid, parity_err, frame_err, overflow, busy, frame_cmd, frame_len, rd_data} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%b busy=%b cmd=%0h len=%0d rd=%0h required all 0", frame_valid, busy, frame_cmd, frame_len, rd_data);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (12 * C) @(negedge clk);
        q = '{8'hFE, 8'h03, 8'h0A, 8'h11, 8'h22, 8'hEF};
        send_seq(q);
        settle();
        n_checks++;
        if (frame_valid !== 1'b1 || frame_cmd !== 8'h0A || frame_len !== 3'd2) begin
            n_fail++;
            $display("FAIL reset_recover: got v=%b cmd=%0h len=%0d required 1/0A/2", frame_valid, frame_cmd, frame_len);
        end
        for (int i = 0; i < MAXP; i++) begin
            rd_idx = IW'(i);
            #1;
            n_checks++;
            if (rd_data !== exp_rd[i]) begin
                n_fail++;
                $display("FAIL reset_recover_rd[%0d]: got %0h required %0h", i, rd_data, exp_rd[i]);
            end
        end
        @(negedge clk);
        do_ack();
        n_checks++;
        if (n_par != e_par || n_frm != e_frm || n_ovf != e_ovf) begin
            n_fail++;
            $display("FAIL reset_pulse_totals: got %0d/%0d/%0d required %0d/%0d/%0d", n_par, n_frm, n_ovf, e_par, e_frm, e_ovf);
        end
    endtask

    task automatic test_random_frames();
        logic [7:0] q[$];
        logic [7:0] b, exp;
        int len;
        for (int it = 0; it < 10; it++) begin
            q.delete();
            for (int j = 0; j < $urandom_range(0, 2); j++) begin
                b = 8'($urandom);
                if (b == 8'hFE) b = 8'h00;
                q.push_back(b);
            end
            len = $urandom_range(1, MAXP + 2);
            q.push_back(8'hFE);
            q.push_back(8'(len));
            for (int j = 0; j < len; j++) q.push_back(8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                b = 8'($urandom);
                if (b == 8'hEF) b = 8'h00;
                q.push_back(b);
            end else begin
                q.push_back(8'hEF);
            end
            foreach (q[i]) send_char(q[i], $urandom_range(0, 14) == 0);
            settle();
            n_checks++;
            if (n_par != e_par || n_frm != e_frm || n_ovf != e_ovf || n_both != e_both) begin
                n_fail++;
                $display("FAIL rand%0d_pulses: got %0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d", it, n_par, n_frm, n_ovf, n_both, e_par, e_frm, e_ovf, e_both);
            end
            n_checks++;
            if (frame_valid !== m_hold) begin
                n_fail++;
                $display("FAIL rand%0d_valid: got %b required %b", it, frame_valid, m_hold);
            end
            if (m_hold) begin
                n_checks++;
                if (frame_cmd !== m_cmd || int'(frame_len) != m_pay.size()) begin
                    n_fail++;
                    $display("FAIL rand%0d_cmd_len: got %0h/%0d required %0h/%0d", it, frame_cmd, frame_len, m_cmd, m_pay.size());
                end
                for (int i = 0; i < MAXP; i++) begin
                    rd_idx = IW'(i);
                    #1;
                    exp = (i < m_pay.size()) ? m_pay[i] : 8'h00;
                    n_checks++;
                    if (rd_data !== exp) begin
                        n_fail++;
                        $display("FAIL rand%0d_rd[%0d]: got %0h required %0h", it, i, rd_data, exp);
                    end
                end
                @(negedge clk);
                do_ack();
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_short_frame();
        test_parity_abort();
        test_len_errors();
        test_hold_and_glitch();
        test_reset_mid();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/uart_cmd_frame_rx.md
# uart_cmd_frame_rx

Parametrised UART receive path with built-in command-frame decoding. Deserialises an asynchronous serial line (configurable data width, parity mode and oversampling), then parses framed commands of the form SOF, L, CMD, payload, EOF into a single-frame payload buffer. It sits between the board RX pin and the command dispatcher. It replaces the fixed 8-bit, even-parity, one-clock-per-bit receive logic.

## Interface
- DATA_W, 8: bits per serial character, range 5..9; all frame bytes are DATA_W wide.
- CLKS_PER_BIT, 16: clk cycles per bit period, minimum 2.
- PARITY, PAR_EVEN: PAR_NONE, PAR_EVEN or PAR_ODD (uart_pkg::parity_e).
- MAX_PAYLOAD, 16: payload buffer depth in characters, minimum 1.
- SOF, 'hFE: start-of-frame character.
- EOF, 'hEF: end-of-frame character.
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- rx_in  in  1  serial line; idles high.
- frame_valid  out  1  complete good frame held in buffer; level signal.
- frame_ack  in  1  consumer releases the frame; sampled only while frame_valid=1.
- frame_cmd  out  DATA_W  CMD character of the held frame.
- frame_len  out  $clog2(MAX_PAYLOAD+1)  payload count (L-1).
- rd_idx  in  $clog2(MAX_PAYLOAD)  payload read index.
- rd_data  out  DATA_W  payload[rd_idx], combinational read; 0 when rd_idx >= frame_len.
- parity_err  out  1  one-cycle pulse per character with bad parity.
- frame_err  out  1  one-cycle pulse on stop-bit error, bad EOF, L=0, or frame aborted by parity error.
- overflow  out  1  one-cycle pulse when L-1 > MAX_PAYLOAD, or a character is dropped while frame_valid=1.
- busy  out  1  high whenever the parser is outside IDLE or the RX core is mid-character.

## Operation
- RX core: rx_in passes through a 2-flop synchroniser. In idle, a falling edge starts the character.
- Start bit is re-sampled CLKS_PER_BIT/2 cycles later. If it reads 1, this is a false start: return to idle with no pulse.
- Data bits are sampled LSB first, every CLKS_PER_BIT cycles from the start-bit mid sample. The parity bit follows if PARITY != PAR_NONE. Then the stop bit is sampled.
- Stop bit = 0: the character is discarded and frame_err is pulsed.
- Parity: EVEN requires the XOR of data and parity bits to be 0. ODD requires it to be 1.
- Parser FSM states: IDLE, LEN, CMD, PAYLOAD, END, HOLD.
  - IDLE: characters other than SOF are silently discarded. SOF moves to LEN.
  - LEN: store L. L=0 causes frame_err and a return to IDLE. L-1 > MAX_PAYLOAD causes overflow and a return to IDLE. Otherwise go to CMD.
  - CMD: store the character. Go to PAYLOAD if L>1, else to END.
  - PAYLOAD: write buffer[cnt] and increment cnt. After L-1 characters, go to END.
  - END: EOF moves to HOLD with frame_valid=1. Any other character causes frame_err and a return to IDLE.
  - HOLD: each received character is dropped and overflow is pulsed. frame_ack=1 returns the parser to IDLE.
- A parity error in any state other than IDLE/HOLD aborts the frame: parity_err and frame_err pulse in the same cycle, and the parser returns to IDLE. In IDLE, only parity_err pulses.
- SOF appearing mid-frame is treated as data; the parser does not resynchronise.
- frame_cmd, frame_len and buffer contents are stable while frame_valid=1. They are undefined otherwise.

## Timing
- Reset: all outputs 0, FSMs in idle, buffer contents don't-care. Reset asserted mid-character or mid-frame discards all partial state immediately.
- Internal character strobe fires on the stop-bit mid-sample cycle. That is 2 + CLKS_PER_BIT/2 + (1 + DATA_W + P)·CLKS_PER_BIT cycles after the rx_in falling edge, where P is 1 if parity is enabled, else 0.
- Error/overflow pulses are registered and appear 1 cycle after the character strobe.
- frame_valid rises 1 cycle after the EOF strobe.
- frame_valid falls in the cycle after frame_ack is sampled high.
- A SOF arriving on the same strobe cycle as frame_ack is dropped with overflow (HOLD still active that cycle).
- Back-to-back characters with zero idle time between the stop bit and the next start bit are supported.

## Structure
- uart_pkg holds:
  - parity_e.
  - parser state enum.
  - default SOF/EOF constants.
  - function parity_calc(data, mode).
- Sub-module uart_rx_core: synchroniser, bit timer and bit counter. Outputs char_strobe, char_data, par_bad and stop_bad.
- The top level contains the parser FSM, length counter and payload register array.

## Test plan
All scenarios use CLKS_PER_BIT=4, DATA_W=8, PARITY=EVEN, MAX_PAYLOAD=4.
- Send FE,03,01,04,07,EF -> frame_valid=1, frame_cmd=01, frame_len=2, rd_data[0]=04, rd_data[1]=07, rd_data[2]=0. Assert frame_ack -> frame_valid drops the next cycle.
- Send FE,01,02,EF -> frame_cmd=02, frame_len=0. Preceding junk 55,AA before the FE is ignored with no pulses.
- Send FE,03,01 with corrupted parity on the 01 character -> parity_err and frame_err pulse together. Then a full good frame -> accepted.
- Send FE,06,... -> overflow pulse on the L character, parser returns to IDLE. Send FE,02,01,04,33 -> frame_err on the 33 character.
- While frame_valid=1, send FE -> overflow pulse and the held frame is unchanged. Apply a 2-cycle rx_in low glitch -> false start, no pulses.
- Assert reset in the middle of a payload character -> all outputs 0. A subsequent good frame decodes correctly.
